// File: rtl/snake_pkg.sv
// Shared encodings and defaults for the snake movement datapath.
package snake_pkg;

   localparam int SNAKE_GRID_W   = 80;
   localparam int SNAKE_GRID_H   = 60;
   localparam int SNAKE_MAX_LEN  = 15;
   localparam int SNAKE_INIT_LEN = 3;
   localparam int SNAKE_INIT_X   = 40;
   localparam int SNAKE_INIT_Y   = 30;

   typedef enum logic [1:0] {
      DIR_RIGHT = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_UP    = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      G_IDLE = 2'd0,
      G_RUN  = 2'd1,
      G_OVER = 2'd2,
      G_INIT = 2'd3
   } game_t;

   typedef enum logic [2:0] {
      S_WAIT    = 3'd0,
      S_TURN    = 3'd1,
      S_PREDICT = 3'd2,
      S_SHIFT   = 3'd3,
      S_HEAD    = 3'd4,
      S_CHECK   = 3'd5,
      S_DONE    = 3'd6
   } seq_t;

   typedef struct packed {
      logic [6:0] x;
      logic [6:0] y;
   } pos_t;

   // Per-direction step in 8-bit two's complement; the extra bit lets a
   // step below zero show up as a large value that fails the wall compare.
   localparam logic [7:0] STEP_DX [4] = '{8'h01, 8'h00, 8'hFF, 8'h00};
   localparam logic [7:0] STEP_DY [4] = '{8'h00, 8'h01, 8'h00, 8'hFF};

endpackage

// File: rtl/snake_segment_store.sv
// Segment position register array with shift, head-write and two read ports.
module snake_segment_store
   import snake_pkg::*;
#(
   parameter int MAX_LEN  = SNAKE_MAX_LEN,
   parameter int INIT_LEN = SNAKE_INIT_LEN,
   parameter int INIT_X   = SNAKE_INIT_X,
   parameter int INIT_Y   = SNAKE_INIT_Y
) (
   input  logic       clock_25,
   input  logic       reset,
   input  logic       init_load,
   input  logic       shift_en,
   input  logic [3:0] shift_idx,
   input  logic       head_we,
   input  pos_t       head_wdata,
   input  logic [3:0] rd_idx,
   output pos_t       rd_pos,
   input  logic [3:0] chk_idx,
   output pos_t       chk_pos,
   output pos_t       head_pos
);

   localparam logic [3:0] MAX_LEN_L = 4'(MAX_LEN);

   pos_t seg_q [MAX_LEN];

   function automatic pos_t init_pos(input int i);
      pos_t p;
      p = '0;
      if (i < INIT_LEN) begin
         p.x = 7'(INIT_X - i);
         p.y = 7'(INIT_Y);
      end
      return p;
   endfunction

   // Load the starting body on reset/restart, otherwise shift one slot or write the head.
   always_ff @(posedge clock_25) begin
      if (reset || init_load) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_q[i] <= init_pos(i);
         end
      end else begin
         if (shift_en && (shift_idx != 4'd0) && (shift_idx < MAX_LEN_L)) begin
            seg_q[shift_idx] <= seg_q[shift_idx - 4'd1];
         end
         if (head_we) begin
            seg_q[0] <= head_wdata;
         end
      end
   end

   // Renderer and collision-scan reads; indices past the array read as (0,0).
   always_comb begin
      rd_pos   = '0;
      chk_pos  = '0;
      head_pos = seg_q[0];
      if (rd_idx < MAX_LEN_L) begin
         rd_pos = seg_q[rd_idx];
      end
      if (chk_idx < MAX_LEN_L) begin
         chk_pos = seg_q[chk_idx];
      end
   end

endmodule

// File: rtl/snake_move_sequencer.sv
// Per-tick snake update sequencer and game state controller.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  G_IDLE     | waiting for first button press after reset
//  G_RUN      | game active, ticks start updates
//  G_OVER     | wall or self hit; waiting for a button to restart
//  G_INIT     | one cycle reload of start position, length, dir, score
//  S_WAIT     | sequencer idle, accepts game_tik in G_RUN
//  S_TURN     | apply latched turn, compute next head
//  S_PREDICT  | wall check and fruit compare
//  S_SHIFT    | copy seg[k-1] to seg[k], k counting down to 1
//  S_HEAD     | write new head, grow length/score on fruit
//  S_CHECK    | compare head against seg[k], k counting down to 1
//  S_DONE     | update_done pulse
module snake_move_sequencer
   import snake_pkg::*;
#(
   parameter int GRID_W   = SNAKE_GRID_W,
   parameter int GRID_H   = SNAKE_GRID_H,
   parameter int MAX_LEN  = SNAKE_MAX_LEN,
   parameter int INIT_LEN = SNAKE_INIT_LEN,
   parameter int INIT_X   = SNAKE_INIT_X,
   parameter int INIT_Y   = SNAKE_INIT_Y
) (
   input  logic       clock_25,
   input  logic       reset,
   input  logic       game_tik,
   input  logic       right,
   input  logic       left,
   input  logic [6:0] fruit_x,
   input  logic [6:0] fruit_y,
   input  logic       fruit_valid,
   input  logic [3:0] seg_rd_idx,
   output logic [6:0] seg_rd_x,
   output logic [6:0] seg_rd_y,
   output logic [6:0] snake_head_x,
   output logic [6:0] snake_head_y,
   output logic [3:0] snake_length,
   output logic [7:0] score,
   output logic       fruit_eaten,
   output logic       collision_detected,
   output logic       busy,
   output logic       update_done
);

   localparam logic [7:0] GRID_W_L   = 8'(GRID_W);
   localparam logic [7:0] GRID_H_L   = 8'(GRID_H);
   localparam logic [3:0] MAX_LEN_L  = 4'(MAX_LEN);
   localparam logic [3:0] INIT_LEN_L = 4'(INIT_LEN);

   game_t      game_q, game_d;
   seq_t       seq_q, seq_d;
   dir_t       dir_q, dir_d;
   logic [3:0] len_q, len_d;
   logic [3:0] idx_q, idx_d;
   logic [7:0] score_q, score_d;
   logic [7:0] nh_x_q, nh_x_d;
   logic [7:0] nh_y_q, nh_y_d;
   logic       grow_q, grow_d;
   logic       pend_r_q, pend_l_q;
   logic       pend_clr;
   logic       shift_en;
   logic       head_we;
   logic       init_load;
   logic       btn;
   pos_t       rd_pos;
   pos_t       chk_pos;
   pos_t       head_pos;
   pos_t       head_wdata;

   assign btn        = right | left;
   assign head_wdata = '{x: nh_x_q[6:0], y: nh_y_q[6:0]};

   snake_segment_store #(
      .MAX_LEN  (MAX_LEN),
      .INIT_LEN (INIT_LEN),
      .INIT_X   (INIT_X),
      .INIT_Y   (INIT_Y)
   ) u_store (
      .clock_25   (clock_25),
      .reset      (reset),
      .init_load  (init_load),
      .shift_en   (shift_en),
      .shift_idx  (idx_q),
      .head_we    (head_we),
      .head_wdata (head_wdata),
      .rd_idx     (seg_rd_idx),
      .rd_pos     (rd_pos),
      .chk_idx    (idx_q),
      .chk_pos    (chk_pos),
      .head_pos   (head_pos)
   );

   // State, counters and latched turn requests.
   always_ff @(posedge clock_25) begin
      if (reset) begin
         game_q   <= G_IDLE;
         seq_q    <= S_WAIT;
         dir_q    <= DIR_RIGHT;
         len_q    <= INIT_LEN_L;
         idx_q    <= '0;
         score_q  <= '0;
         nh_x_q   <= '0;
         nh_y_q   <= '0;
         grow_q   <= 1'b0;
         pend_r_q <= 1'b0;
         pend_l_q <= 1'b0;
      end else begin
         game_q   <= game_d;
         seq_q    <= seq_d;
         dir_q    <= dir_d;
         len_q    <= len_d;
         idx_q    <= idx_d;
         score_q  <= score_d;
         nh_x_q   <= nh_x_d;
         nh_y_q   <= nh_y_d;
         grow_q   <= grow_d;
         // A pulse landing in the TURN cycle survives for the next tick.
         pend_r_q <= (pend_r_q & ~pend_clr) | (right & (game_q == G_RUN));
         pend_l_q <= (pend_l_q & ~pend_clr) | (left & (game_q == G_RUN));
      end
   end

   // Next-state logic for the update sequence and the game state.
   always_comb begin
      game_d    = game_q;
      seq_d     = seq_q;
      dir_d     = dir_q;
      len_d     = len_q;
      idx_d     = idx_q;
      score_d   = score_q;
      nh_x_d    = nh_x_q;
      nh_y_d    = nh_y_q;
      grow_d    = grow_q;
      pend_clr  = 1'b0;
      shift_en  = 1'b0;
      head_we   = 1'b0;
      init_load = 1'b0;

      unique case (seq_q)
         S_WAIT: begin
            if ((game_q == G_RUN) && game_tik) begin
               seq_d = S_TURN;
            end
         end
         S_TURN: begin
            pend_clr = 1'b1;
            if (pend_r_q && !pend_l_q) begin
               dir_d = dir_t'(2'(dir_q + 2'd1));
            end else if (pend_l_q && !pend_r_q) begin
               dir_d = dir_t'(2'(dir_q - 2'd1));
            end
            nh_x_d = {1'b0, head_pos.x} + STEP_DX[dir_d];
            nh_y_d = {1'b0, head_pos.y} + STEP_DY[dir_d];
            seq_d  = S_PREDICT;
         end
         S_PREDICT: begin
            if ((nh_x_q >= GRID_W_L) || (nh_y_q >= GRID_H_L)) begin
               game_d = G_OVER;
               seq_d  = S_DONE;
            end else begin
               grow_d = fruit_valid && (nh_x_q[6:0] == fruit_x) && (nh_y_q[6:0] == fruit_y);
               if (grow_d && (len_q < MAX_LEN_L)) begin
                  idx_d = len_q;
               end else begin
                  idx_d = len_q - 4'd1;
               end
               seq_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            shift_en = 1'b1;
            if (idx_q <= 4'd1) begin
               seq_d = S_HEAD;
            end else begin
               idx_d = idx_q - 4'd1;
            end
         end
         S_HEAD: begin
            head_we = 1'b1;
            if (grow_q) begin
               if (len_q < MAX_LEN_L) begin
                  len_d = len_q + 4'd1;
               end
               if (score_q != 8'hFF) begin
                  score_d = score_q + 8'd1;
               end
            end
            idx_d = len_d - 4'd1;
            seq_d = S_CHECK;
         end
         S_CHECK: begin
            if (chk_pos == head_pos) begin
               game_d = G_OVER;
               seq_d  = S_DONE;
            end else if (idx_q <= 4'd1) begin
               seq_d = S_DONE;
            end else begin
               idx_d = idx_q - 4'd1;
            end
         end
         S_DONE: begin
            seq_d = S_WAIT;
         end
         default: begin
            seq_d = S_WAIT;
         end
      endcase

      unique case (game_q)
         G_IDLE: begin
            if (btn) begin
               game_d = G_RUN;
            end
         end
         G_OVER: begin
            if (btn) begin
               game_d = G_INIT;
            end
         end
         G_INIT: begin
            init_load = 1'b1;
            pend_clr  = 1'b1;
            len_d     = INIT_LEN_L;
            dir_d     = DIR_RIGHT;
            score_d   = '0;
            idx_d     = '0;
            grow_d    = 1'b0;
            seq_d     = S_WAIT;
            game_d    = G_RUN;
         end
         default: ;
      endcase
   end

   // Status and read-back outputs, decoded from registered state.
   always_comb begin
      seg_rd_x           = rd_pos.x;
      seg_rd_y           = rd_pos.y;
      snake_head_x       = head_pos.x;
      snake_head_y       = head_pos.y;
      snake_length       = len_q;
      score              = score_q;
      fruit_eaten        = (seq_q == S_HEAD) && grow_q;
      collision_detected = (game_q == G_OVER);
      busy               = (seq_q != S_WAIT) && (seq_q != S_DONE);
      update_done        = (seq_q == S_DONE);
   end

endmodule

// File: tb/tb_snake_move_sequencer.sv
// Directed bench for snake_move_sequencer.
module tb_snake_move_sequencer;

   logic       clock_25 = 1'b0;
   logic       reset;
   logic       game_tik;
   logic       right;
   logic       left;
   logic [6:0] fruit_x;
   logic [6:0] fruit_y;
   logic       fruit_valid;
   logic [3:0] seg_rd_idx;
   logic [6:0] seg_rd_x;
   logic [6:0] seg_rd_y;
   logic [6:0] snake_head_x;
   logic [6:0] snake_head_y;
   logic [3:0] snake_length;
   logic [7:0] score;
   logic       fruit_eaten;
   logic       collision_detected;
   logic       busy;
   logic       update_done;

   int errors = 0;
   int checks = 0;
   int bsy, dn, fe, fe_total;

   snake_move_sequencer dut (
      .clock_25           (clock_25),
      .reset              (reset),
      .game_tik           (game_tik),
      .right              (right),
      .left               (left),
      .fruit_x            (fruit_x),
      .fruit_y            (fruit_y),
      .fruit_valid        (fruit_valid),
      .seg_rd_idx         (seg_rd_idx),
      .seg_rd_x           (seg_rd_x),
      .seg_rd_y           (seg_rd_y),
      .snake_head_x       (snake_head_x),
      .snake_head_y       (snake_head_y),
      .snake_length       (snake_length),
      .score              (score),
      .fruit_eaten        (fruit_eaten),
      .collision_detected (collision_detected),
      .busy               (busy),
      .update_done        (update_done)
   );

   always #20 clock_25 = ~clock_25;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_core(input string tag, input int hx, input int hy, input int len, input int sc);
      check({tag, "_head_x"}, 32'(snake_head_x), hx);
      check({tag, "_head_y"}, 32'(snake_head_y), hy);
      check({tag, "_length"}, 32'(snake_length), len);
      check({tag, "_score"}, 32'(score), sc);
   endtask

   task automatic check_seg(input string tag, input int idx, input int ex, input int ey);
      seg_rd_idx = 4'(idx);
      #1;
      check({tag, "_seg_x"}, 32'(seg_rd_x), ex);
      check({tag, "_seg_y"}, 32'(seg_rd_y), ey);
   endtask

   task automatic pulse(input logic r, input logic l);
      @(negedge clock_25);
      right = r;
      left  = l;
      @(negedge clock_25);
      right = 1'b0;
      left  = 1'b0;
   endtask

   // One tick; counts busy cycles and pulses until update_done (bounded).
   task automatic do_tick();
      @(negedge clock_25);
      game_tik = 1'b1;
      @(negedge clock_25);
      game_tik = 1'b0;
      bsy = 0;
      dn  = 0;
      fe  = 0;
      for (int c = 0; c < 60; c++) begin
         if (busy) bsy++;
         if (fruit_eaten) fe++;
         if (update_done) begin
            dn++;
            break;
         end
         @(negedge clock_25);
      end
      @(negedge clock_25);
   endtask

   initial begin
      reset       = 1'b1;
      game_tik    = 1'b0;
      right       = 1'b0;
      left        = 1'b0;
      fruit_x     = '0;
      fruit_y     = '0;
      fruit_valid = 1'b0;
      seg_rd_idx  = '0;
      repeat (2) @(negedge clock_25);
      reset = 1'b0;

      check_core("reset", 40, 30, 3, 0);
      check("reset_busy", 32'(busy), 0);
      check("reset_coll", 32'(collision_detected), 0);
      check("reset_done", 32'(update_done), 0);
      check("reset_fe", 32'(fruit_eaten), 0);
      check_seg("reset1", 1, 39, 30);
      check_seg("reset2", 2, 38, 30);
      check_seg("reset3", 3, 0, 0);

      do_tick();
      check("idle_tik_done", dn, 0);
      check_core("idle_tik", 40, 30, 3, 0);

      pulse(1'b1, 1'b0);
      do_tick();
      check("start_done", dn, 1);
      check("start_busy", bsy, 7);
      check_core("start", 41, 30, 3, 0);
      check_seg("start1", 1, 40, 30);
      check_seg("start2", 2, 39, 30);
      check_seg("start3", 3, 0, 0);

      pulse(1'b1, 1'b1);
      do_tick();
      check_core("both", 42, 30, 3, 0);

      pulse(1'b1, 1'b0);
      do_tick();
      check_core("turn_down", 42, 31, 3, 0);
      check_seg("turn1", 1, 42, 30);
      check_seg("turn2", 2, 41, 30);

      fruit_x = 7'd42; fruit_y = 7'd32; fruit_valid = 1'b1;
      do_tick();
      fruit_valid = 1'b0;
      check("fruit_fe", fe, 1);
      check("fruit_busy", bsy, 9);
      check_core("fruit", 42, 32, 4, 1);
      check_seg("fruit_tail", 3, 41, 30);

      // Length 4 circling a 2x2 square keeps stepping into its own old tail.
      pulse(1'b1, 1'b0); do_tick();
      check_core("sq1", 41, 32, 4, 1);
      check("sq1_coll", 32'(collision_detected), 0);
      pulse(1'b1, 1'b0); do_tick();
      check_core("sq2", 41, 31, 4, 1);
      check("sq2_coll", 32'(collision_detected), 0);
      pulse(1'b1, 1'b0); do_tick();
      check_core("sq3", 42, 31, 4, 1);
      check("sq3_coll", 32'(collision_detected), 0);
      pulse(1'b1, 1'b0); do_tick();
      check_core("sq4", 42, 32, 4, 1);
      check("sq4_coll", 32'(collision_detected), 0);
      check_seg("sq4_tail", 3, 41, 32);

      fruit_x = 7'd42; fruit_y = 7'd33; fruit_valid = 1'b1;
      do_tick();
      fruit_valid = 1'b0;
      check_core("len5", 42, 33, 5, 2);
      check_seg("len5_tail", 4, 41, 32);

      pulse(1'b1, 1'b0); do_tick();
      check_core("self1", 41, 33, 5, 2);
      check("self1_coll", 32'(collision_detected), 0);
      pulse(1'b1, 1'b0); do_tick();
      check_core("self2", 41, 32, 5, 2);
      check("self2_coll", 32'(collision_detected), 0);
      pulse(1'b1, 1'b0); do_tick();
      check("self3_coll", 32'(collision_detected), 1);
      check("self3_done", dn, 1);
      check_core("self3", 42, 32, 5, 2);

      do_tick();
      check("over_tik_done", dn, 0);
      check_core("over_tik", 42, 32, 5, 2);

      pulse(1'b0, 1'b1);
      @(negedge clock_25);
      check_core("restart", 40, 30, 3, 0);
      check("restart_coll", 32'(collision_detected), 0);
      check_seg("restart2", 2, 38, 30);
      check_seg("restart4", 4, 0, 0);

      pulse(1'b0, 1'b1);
      do_tick();
      check_core("up1", 40, 29, 3, 0);
      repeat (29) do_tick();
      check_core("up_top", 40, 0, 3, 0);
      check("up_top_coll", 32'(collision_detected), 0);
      do_tick();
      check("wall_coll", 32'(collision_detected), 1);
      check("wall_done", dn, 1);
      check("wall_busy", bsy, 2);
      check_core("wall", 40, 0, 3, 0);

      pulse(1'b1, 1'b0);
      @(negedge clock_25);
      check_core("restart_b", 40, 30, 3, 0);

      fe_total = 0;
      for (int i = 0; i < 12; i++) begin
         fruit_x = 7'(41 + i); fruit_y = 7'd30; fruit_valid = 1'b1;
         do_tick();
         fe_total += fe;
      end
      check("grow_fe_total", fe_total, 12);
      check_core("grow15", 52, 30, 15, 12);

      fruit_x = 7'd53; fruit_y = 7'd30; fruit_valid = 1'b1;
      do_tick();
      fruit_valid = 1'b0;
      check("sat_fe", fe, 1);
      check("sat_busy", bsy, 31);
      check_core("sat", 53, 30, 15, 13);
      check_seg("sat14", 14, 39, 30);
      check_seg("sat15", 15, 0, 0);

      // Second tik lands while busy and must be dropped.
      @(negedge clock_25); game_tik = 1'b1;
      @(negedge clock_25); game_tik = 1'b0;
      @(negedge clock_25); game_tik = 1'b1;
      @(negedge clock_25); game_tik = 1'b0;
      dn = 0;
      for (int c = 0; c < 80; c++) begin
         if (update_done) dn++;
         @(negedge clock_25);
      end
      check("overrun_done", dn, 1);
      check_core("overrun", 54, 30, 15, 13);

      @(negedge clock_25); game_tik = 1'b1;
      @(negedge clock_25); game_tik = 1'b0;
      @(negedge clock_25);
      @(negedge clock_25);
      check("midreset_busy_pre", 32'(busy), 1);
      reset = 1'b1;
      @(negedge clock_25);
      reset = 1'b0;
      check_core("midreset", 40, 30, 3, 0);
      check("midreset_busy", 32'(busy), 0);
      check("midreset_coll", 32'(collision_detected), 0);
      check_seg("midreset3", 3, 0, 0);
      check_seg("midreset14", 14, 0, 0);
      do_tick();
      check("midreset_idle_done", dn, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
